sigmoid_rom_arbiter: RTL and testbench

- Shares one single-port synchronous sigmoid lookup ROM (14-bit address, 8-bit data, 1-cycle read latency) among NUM_REQ neuron units.
- Grants at most one request per cycle using round-robin arbitration.
- Drives the ROM address and returns each looked-up activation to its requester, with a fixed latency and an id tag.
- Sits between the neuron accumulators and the sigmoid ROM instance; the ROM itself is external.

---
 rtl/sigmoid_rom_arbiter.sv | 121 ++++++++++++
 tb/tb_sigmoid_rom_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_rom_arbiter.sv
// sigmoid_rom_arbiter: round-robin sharing of one synchronous sigmoid ROM
// among NUM_REQ neuron units. Grant and ROM address are combinational; the
// response (data + id tag) appears exactly two cycles after the grant.
// Optional macro SIGMOID_ROM_ARB_PERF_EN adds saturating lookup/stall counters.
module sigmoid_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_q,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ID_WIDTH-1:0]           resp_id
`ifdef SIGMOID_ROM_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_lookups,
    output logic [31:0]                   perf_stall
`endif
);

    logic [ID_WIDTH-1:0]   ptr;
    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   cand;
    int unsigned           idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [ADDR_WIDTH-1:0] addr_shadow;
    logic                  s1_valid;
    logic [ID_WIDTH-1:0]   s1_id;

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        cand       = '0;
        idx        = 0;
        req_ready  = '0;
        grant_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(ptr) + k) % NUM_REQ;
            cand = idx[ID_WIDTH-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (reset) begin
            grant_any = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_any && grant_idx == ID_WIDTH'(i)) begin
                req_ready[i] = 1'b1;
                grant_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // ROM address follows the grant, otherwise holds the last issued address.
    always_comb begin
        rom_addr = grant_any ? grant_addr : addr_shadow;
    end

    // Pointer, address shadow and the two-stage response pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            addr_shadow <= '0;
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_id     <= '0;
        end else begin
            if (grant_any) begin
                ptr         <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
                addr_shadow <= grant_addr;
            end
            s1_valid <= grant_any;
            s1_id    <= grant_idx;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                resp_valid[i] <= s1_valid && (s1_id == ID_WIDTH'(i));
            end
            if (s1_valid) begin
                resp_data <= rom_q;
                resp_id   <= s1_id;
            end
        end
    end

`ifdef SIGMOID_ROM_ARB_PERF_EN
    logic stall_cycle;

    // A stall cycle is any cycle with at least one valid request left ungranted.
    always_comb begin
        stall_cycle = |(req_valid & ~req_ready);
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lookups <= '0;
            perf_stall   <= '0;
        end else begin
            if (grant_any && perf_lookups != '1) begin
                perf_lookups <= perf_lookups + 32'd1;
            end
            if (stall_cycle && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_rom_arbiter.sv
// Self-checking bench for sigmoid_rom_arbiter (NUM_REQ=4), with a registered
// ROM model rom_q = rom_addr[7:0] ^ 8'h5A.
module tb_sigmoid_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [55:0] req_addr;
    logic [3:0]  req_ready;
    logic [13:0] rom_addr;
    logic [7:0]  rom_q;
    logic [3:0]  resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
`ifdef SIGMOID_ROM_ARB_PERF_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_stall;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // ROM model, one-cycle read latency
    always @(posedge clk) rom_q <= rom_addr[7:0] ^ 8'h5A;

    sigmoid_rom_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef SIGMOID_ROM_ARB_PERF_EN
        ,
        .perf_lookups (perf_lookups),
        .perf_stall   (perf_stall)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [13:0] a0, a1, a2, a3;
        logic [3:0]  ready;
        logic [13:0] rom;
        logic [3:0]  rv;
        logic [1:0]  id;
        logic [7:0]  data;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] valid, input logic [13:0] a0, a1, a2, a3,
                       input logic [3:0] ready, input logic [13:0] rom,
                       input logic [3:0] rv, input logic [1:0] id, input logic [7:0] data);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.ready = ready; v.rom = rom; v.rv = rv; v.id = id; v.data = data;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [13:0] a0, a1, a2, a3);
        @(negedge clk);
        req_valid = valid;
        req_addr  = {a3, a2, a1, a0};
        #1;
    endtask

    logic [7:0] tbl [4] = '{8'h5B, 8'h58, 8'h59, 8'h5E};

    initial begin
        int unsigned g, r;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        repeat (2) drive(4'b0000, 0, 0, 0, 0);
        check("reset_ready", 32'(req_ready), 0);
        check("reset_resp_valid", 32'(resp_valid), 0);
        check("reset_resp_data", 32'(resp_data), 0);
        check("reset_resp_id", 32'(resp_id), 0);
        check("reset_rom_addr", 32'(rom_addr), 0);
        @(negedge clk);
        reset = 1'b0;

        // single request, then move pointer to 0 via requester 3
        add(4'b0100, 0, 0, 14'h1234, 0, 4'b0100, 14'h1234, 4'b0000, 0, 8'h00);
        add(4'b0000, 0, 0, 0, 0,        4'b0000, 14'h1234, 4'b0000, 0, 8'h00);
        add(4'b0000, 0, 0, 0, 0,        4'b0000, 14'h1234, 4'b0100, 2, 8'h6E);
        add(4'b1000, 0, 0, 0, 14'h0ABC, 4'b1000, 14'h0ABC, 4'b0000, 2, 8'h6E);
        add(4'b0000, 0, 0, 0, 0,        4'b0000, 14'h0ABC, 4'b0000, 2, 8'h6E);
        add(4'b0000, 0, 0, 0, 0,        4'b0000, 14'h0ABC, 4'b1000, 3, 8'hE6);
        // fairness: all four valid for 8 cycles
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            if (k < 2) add(4'b1111, 1, 2, 3, 4, 4'(1 << g), 14'(g + 1), 4'b0000, 3, 8'hE6);
            else begin
                r = (k - 2) % 4;
                add(4'b1111, 1, 2, 3, 4, 4'(1 << g), 14'(g + 1), 4'(1 << r), 2'(r), tbl[r]);
            end
        end
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 14'h0004, 4'b0100, 2, 8'h59);
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 14'h0004, 4'b1000, 3, 8'h5E);
        // contention after a grant: 1, then {0,1} -> 0, then 1
        add(4'b0010, 0, 14'h0100, 0, 0,        4'b0010, 14'h0100, 4'b0000, 3, 8'h5E);
        add(4'b0011, 14'h0200, 14'h0101, 0, 0, 4'b0001, 14'h0200, 4'b0000, 3, 8'h5E);
        add(4'b0010, 0, 14'h0101, 0, 0,        4'b0010, 14'h0101, 4'b0010, 1, 8'h5A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0101, 4'b0001, 0, 8'h5A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0101, 4'b0010, 1, 8'h5B);
        // withdrawn request from 3 while 0 holds the grant
        add(4'b1000, 0, 0, 0, 14'h0010,        4'b1000, 14'h0010, 4'b0000, 1, 8'h5B);
        add(4'b1001, 14'h0020, 0, 0, 14'h0030, 4'b0001, 14'h0020, 4'b0000, 1, 8'h5B);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0020, 4'b1000, 3, 8'h4A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0020, 4'b0001, 0, 8'h7A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0020, 4'b0000, 0, 8'h7A);
        add(4'b1011, 14'h0020, 14'h0040, 0, 14'h0030, 4'b0010, 14'h0040, 4'b0000, 0, 8'h7A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0040, 4'b0000, 0, 8'h7A);
        add(4'b0000, 0, 0, 0, 0,               4'b0000, 14'h0040, 4'b0010, 1, 8'h1A);

        foreach (vq[i]) begin
            drive(vq[i].valid, vq[i].a0, vq[i].a1, vq[i].a2, vq[i].a3);
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vq[i].ready));
            check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vq[i].rom));
            check($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vq[i].rv));
            check($sformatf("v%0d_resp_id", i), 32'(resp_id), 32'(vq[i].id));
            check($sformatf("v%0d_resp_data", i), 32'(resp_data), 32'(vq[i].data));
        end

        // reset while a lookup is in flight
        drive(4'b0100, 0, 0, 14'h0077, 0);
        check("rst_seq_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        reset = 1'b1; req_valid = 4'b0000; #1;
        check("rst_seq_ready_low", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b0; #1;
        check("rst_seq_no_resp0", 32'(resp_valid), 0);
        check("rst_seq_data0", 32'(resp_data), 0);
        check("rst_seq_id0", 32'(resp_id), 0);
        check("rst_seq_rom0", 32'(rom_addr), 0);
`ifdef SIGMOID_ROM_ARB_PERF_EN
        check("perf_lookups_rst", perf_lookups, 0);
        check("perf_stall_rst", perf_stall, 0);
`endif
        drive(4'b0000, 0, 0, 0, 0);
        check("rst_seq_no_resp1", 32'(resp_valid), 0);
        drive(4'b0010, 0, 14'h0005, 0, 0);
        check("post_rst_grant", 32'(req_ready), 32'(4'b0010));
        check("post_rst_rom", 32'(rom_addr), 32'(14'h0005));
        drive(4'b0000, 0, 0, 0, 0);
        check("post_rst_lat1", 32'(resp_valid), 0);
        drive(4'b0000, 0, 0, 0, 0);
        check("post_rst_resp", 32'(resp_valid), 32'(4'b0010));
        check("post_rst_id", 32'(resp_id), 1);
        check("post_rst_data", 32'(resp_data), 32'(8'h5F));

`ifdef SIGMOID_ROM_ARB_PERF_EN
        // three simultaneous requests held until granted
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drive(4'b0111, 1, 2, 3, 0);
        check("perf_g0", 32'(req_ready), 32'(4'b0001));
        drive(4'b0110, 1, 2, 3, 0);
        check("perf_g1", 32'(req_ready), 32'(4'b0010));
        drive(4'b0100, 1, 2, 3, 0);
        check("perf_g2", 32'(req_ready), 32'(4'b0100));
        drive(4'b0000, 0, 0, 0, 0);
        check("perf_lookups", perf_lookups, 3);
        check("perf_stall", perf_stall, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
